tdc_readout: RTL

Readout controller and thermometer decoder for the 16-stage delay-line TDC. On request, it drives the TDC output byte-select line. It then captures the low and high bytes of the 16-bit thermometer code from the shared 8-bit output bus and assembles them. Finally, it converts the code to a 5-bit binary count with a bubble flag and presents the result on a valid/ready interface. It sits on the consumer side of the TDC's multiplexed byte bus, on a harness FPGA or in a neighbouring tile.

---
 rtl/tdc_readout.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tdc_readout.sv
// Readout controller for the 16-stage delay-line TDC: reads the code as two bytes
// over the shared bus, then presents a popcount and a bubble flag on a valid/ready port.
module tdc_readout #(
   parameter int unsigned SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_req,
   input  logic [7:0]  tdc_byte,
   output logic        sel,
   output logic        busy,
   output logic [15:0] raw_code,
   output logic [4:0]  code,
   output logic        bubble,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int unsigned CW = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      S_LO  = 3'd1,
      S_HI  = 3'd2,
      S_DEC = 3'd3,
      S_OUT = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    lo_q, lo_d;
   logic [7:0]    hi_q, hi_d;
   logic [15:0]   raw_q, raw_d;
   logic [4:0]    code_q, code_d;
   logic          bubble_q, bubble_d;
   logic          sel_q, sel_d;
   logic          busy_q, busy_d;
   logic          valid_q, valid_d;

   logic [15:0]   raw_c;
   logic [4:0]    code_c;
   logic [16:0]   therm_c;
   logic          bubble_c;

   // Decode of the captured bytes: popcount and clean-thermometer test.
   always_comb begin
      raw_c   = {hi_q, lo_q};
      code_c  = '0;
      for (int i = 0; i < 16; i++) begin
         code_c = code_c + 5'(raw_c[i]);
      end
      therm_c  = (17'(1) << code_c) - 17'(1);
      bubble_c = (therm_c != {1'b0, raw_c});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         raw_q    <= '0;
         code_q   <= '0;
         bubble_q <= 1'b0;
         sel_q    <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         raw_q    <= raw_d;
         code_q   <= code_d;
         bubble_q <= bubble_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
      end
   end

   // Next state; the settle counter loads SETTLE on entry and the byte is taken when it reaches 1.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      raw_d    = raw_q;
      code_d   = code_q;
      bubble_d = bubble_q;

      case (state_q)
         IDLE: begin
            if (start_req) begin
               state_d = S_LO;
               cnt_d   = CW'(SETTLE);
            end
         end
         S_LO: begin
            if (cnt_q == CW'(1)) begin
               lo_d    = tdc_byte;
               state_d = S_HI;
               cnt_d   = CW'(SETTLE);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HI: begin
            if (cnt_q == CW'(1)) begin
               hi_d    = tdc_byte;
               state_d = S_DEC;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DEC: begin
            raw_d    = raw_c;
            code_d   = code_c;
            bubble_d = bubble_c;
            state_d  = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control outputs are registered from the next state so they line up with the state register.
   always_comb begin
      sel_d   = (state_d == S_HI);
      busy_d  = (state_d != IDLE);
      valid_d = (state_d == S_OUT);
   end

   assign sel       = sel_q;
   assign busy      = busy_q;
   assign raw_code  = raw_q;
   assign code      = code_q;
   assign bubble    = bubble_q;
   assign out_valid = valid_q;

endmodule
